// File: rtl/trig_pkg.sv
// trig_pkg: shared types and defaults for the master trigger issue stage.
package trig_pkg;
    typedef enum logic {STOP, RUN} trig_state_t;
    typedef enum logic [1:0] {REJ_NONE, REJ_DEAD, REJ_HOLDOFF, REJ_BUSY} rej_reason_t;
    localparam int NBUF_DEFAULT = 4;
    localparam int HOLDOFF_DEFAULT = 16;
    typedef logic [$clog2(NBUF_DEFAULT)-1:0] buf_idx_t;
endpackage

// File: rtl/trig_reject_counter.sv
// trig_reject_counter: saturating counter with synchronous clear and increment enable.
module trig_reject_counter #(
    parameter int REJ_WIDTH = 16
) (
    input  logic                 sys_clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 inc_i,
    output logic [REJ_WIDTH-1:0] cnt_o
);
    logic [REJ_WIDTH-1:0] cnt_q;
    logic [REJ_WIDTH-1:0] cnt_d;

    always_comb cnt_d = (rst_i || clr_i) ? '0 : cnt_q + REJ_WIDTH'(inc_i && !(&cnt_q));

    always_ff @(posedge sys_clk_i) cnt_q <= cnt_d;

    assign cnt_o = cnt_q;
endmodule

// File: rtl/trig_issue_gate.sv
// trig_issue_gate: qualifies trigger requests, numbers accepted triggers and
// issues a held readout command; rejected requests are counted by reason.
module trig_issue_gate
    import trig_pkg::*;
#(
    parameter int HOLDOFF     = HOLDOFF_DEFAULT,
    parameter int NBUF        = NBUF_DEFAULT,
    parameter int EVNUM_WIDTH = 32,
    parameter int REJ_WIDTH   = 16
) (
    input  logic                     sys_clk_i,
    input  logic                     rst_i,
    input  logic                     runrst_i,
    input  logic                     runstop_i,
    input  logic                     trig_req_i,
    input  logic                     dead_i,
    output logic                     trig_o,
    output logic [$clog2(NBUF)-1:0]  trig_buf_o,
    output logic [EVNUM_WIDTH-1:0]   trig_evnum_o,
    output logic                     cmd_valid_o,
    input  logic                     cmd_ready_i,
    output logic [$clog2(NBUF)-1:0]  cmd_buf_o,
    output logic [EVNUM_WIDTH-1:0]   cmd_evnum_o,
    output logic                     running_o,
    output logic [REJ_WIDTH-1:0]     rej_dead_o,
    output logic [REJ_WIDTH-1:0]     rej_holdoff_o,
    output logic [REJ_WIDTH-1:0]     rej_busy_o
);
    localparam int BW = $clog2(NBUF);
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = (HOLDOFF > 1) ? HW'(HOLDOFF - 1) : '0;

    trig_state_t             state_q, state_d;
    rej_reason_t             reason;
    logic                    running_q, trig_q, cmd_valid_q, req_run, accept;
    logic [BW-1:0]           buf_q, trig_buf_q, cmd_buf_q;
    logic [EVNUM_WIDTH-1:0]  evnum_q, trig_evnum_q, cmd_evnum_q;
    logic [HW-1:0]           hold_q;

    // A request coinciding with a run reset belongs to no run and is dropped.
    always_comb begin
        state_d = runrst_i ? RUN : runstop_i ? STOP : state_q;
        req_run = (state_q == RUN) && trig_req_i && !runrst_i;
        reason  = !req_run                      ? REJ_NONE :
                  dead_i                        ? REJ_DEAD :
                  (hold_q != '0)                ? REJ_HOLDOFF :
                  (cmd_valid_q && !cmd_ready_i) ? REJ_BUSY : REJ_NONE;
        accept  = req_run && (reason == REJ_NONE);
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q      <= STOP;
            running_q    <= 1'b0;
            trig_q       <= 1'b0;
            trig_buf_q   <= '0;
            trig_evnum_q <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_buf_q    <= '0;
            cmd_evnum_q  <= '0;
            evnum_q      <= '0;
            buf_q        <= '0;
            hold_q       <= '0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == RUN);
            trig_q    <= accept;
            if (runrst_i) begin
                evnum_q     <= '0;
                buf_q       <= '0;
                hold_q      <= '0;
                cmd_valid_q <= 1'b0;
            end else if (accept) begin
                trig_buf_q   <= buf_q;
                trig_evnum_q <= evnum_q;
                cmd_valid_q  <= 1'b1;
                cmd_buf_q    <= buf_q;
                cmd_evnum_q  <= evnum_q;
                evnum_q      <= evnum_q + 1'b1;
                buf_q        <= buf_q + 1'b1;
                hold_q       <= HOLD_LOAD;
            end else begin
                if (cmd_ready_i) cmd_valid_q <= 1'b0;
                if (hold_q != '0) hold_q <= hold_q - 1'b1;
            end
        end
    end

    trig_reject_counter #(.REJ_WIDTH(REJ_WIDTH)) u_rej_dead (
        .sys_clk_i(sys_clk_i), .rst_i(rst_i), .clr_i(runrst_i),
        .inc_i(reason == REJ_DEAD), .cnt_o(rej_dead_o)
    );
    trig_reject_counter #(.REJ_WIDTH(REJ_WIDTH)) u_rej_holdoff (
        .sys_clk_i(sys_clk_i), .rst_i(rst_i), .clr_i(runrst_i),
        .inc_i(reason == REJ_HOLDOFF), .cnt_o(rej_holdoff_o)
    );
    trig_reject_counter #(.REJ_WIDTH(REJ_WIDTH)) u_rej_busy (
        .sys_clk_i(sys_clk_i), .rst_i(rst_i), .clr_i(runrst_i),
        .inc_i(reason == REJ_BUSY), .cnt_o(rej_busy_o)
    );

    assign running_o    = running_q;
    assign trig_o       = trig_q;
    assign trig_buf_o   = trig_buf_q;
    assign trig_evnum_o = trig_evnum_q;
    assign cmd_valid_o  = cmd_valid_q;
    assign cmd_buf_o    = cmd_buf_q;
    assign cmd_evnum_o  = cmd_evnum_q;
endmodule

// File: tb/tb_trig_issue_gate.sv
// tb_trig_issue_gate: directed-vector bench for trig_issue_gate (HOLDOFF=16, NBUF=4).
module tb_trig_issue_gate;
    logic        sys_clk_i = 1'b0;
    logic        rst_i, runrst_i, runstop_i, trig_req_i, dead_i, cmd_ready_i;
    logic        trig_o, cmd_valid_o, running_o;
    logic [1:0]  trig_buf_o, cmd_buf_o;
    logic [31:0] trig_evnum_o, cmd_evnum_o;
    logic [15:0] rej_dead_o, rej_holdoff_o, rej_busy_o;
    int          errors = 0;
    int          checks = 0;

    trig_issue_gate dut (
        .sys_clk_i(sys_clk_i), .rst_i(rst_i), .runrst_i(runrst_i), .runstop_i(runstop_i),
        .trig_req_i(trig_req_i), .dead_i(dead_i), .trig_o(trig_o), .trig_buf_o(trig_buf_o),
        .trig_evnum_o(trig_evnum_o), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
        .cmd_buf_o(cmd_buf_o), .cmd_evnum_o(cmd_evnum_o), .running_o(running_o),
        .rej_dead_o(rej_dead_o), .rej_holdoff_o(rej_holdoff_o), .rej_busy_o(rej_busy_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk_i);
    endtask

    task automatic req(input logic d);
        trig_req_i = 1'b1;
        dead_i     = d;
        @(negedge sys_clk_i);
        trig_req_i = 1'b0;
        dead_i     = 1'b0;
    endtask

    task automatic run_reset();
        runrst_i = 1'b1;
        @(negedge sys_clk_i);
        runrst_i = 1'b0;
    endtask

    task automatic trig_chk(input string tag, input logic [63:0] ev, input logic [63:0] bf);
        chk({tag, "_trig"}, trig_o, 1);
        chk({tag, "_ev"}, trig_evnum_o, ev);
        chk({tag, "_buf"}, trig_buf_o, bf);
    endtask

    task automatic rej_chk(input string tag, input logic [63:0] d, input logic [63:0] h, input logic [63:0] b);
        chk({tag, "_rdead"}, rej_dead_o, d);
        chk({tag, "_rhold"}, rej_holdoff_o, h);
        chk({tag, "_rbusy"}, rej_busy_o, b);
    endtask

    initial begin
        rst_i = 1'b1; runrst_i = 1'b0; runstop_i = 1'b0;
        trig_req_i = 1'b0; dead_i = 1'b0; cmd_ready_i = 1'b1;
        idle(2);
        chk("rst_running", running_o, 0);
        chk("rst_trig", trig_o, 0);
        chk("rst_cmdv", cmd_valid_o, 0);
        chk("rst_ev", trig_evnum_o, 0);
        rej_chk("rst", 0, 0, 0);
        rst_i = 1'b0;
        idle(1);
        chk("stop_running", running_o, 0);

        // basic accepts with ready high
        run_reset();
        chk("run_running", running_o, 1);
        idle(4);
        req(0);
        trig_chk("t1a", 0, 0);
        chk("t1a_cmdv", cmd_valid_o, 1);
        chk("t1a_cmdev", cmd_evnum_o, 0);
        idle(1);
        chk("t1a_pulse", trig_o, 0);
        chk("t1a_cmdv_done", cmd_valid_o, 0);
        chk("t1a_hold_ev", trig_evnum_o, 0);
        idle(23);
        req(0);
        trig_chk("t1b", 1, 1);
        rej_chk("t1", 0, 0, 0);

        // holdoff boundary: reject at +10 and +15, accept at +16
        idle(20);
        run_reset();
        req(0);
        trig_chk("t2a", 0, 0);
        idle(9);
        req(0);
        chk("t2_rej10_trig", trig_o, 0);
        chk("t2_rej10", rej_holdoff_o, 1);
        idle(4);
        req(0);
        chk("t2_rej15", rej_holdoff_o, 2);
        req(0);
        trig_chk("t2b", 1, 1);

        // dead beats holdoff; buffer index wraps
        idle(20);
        run_reset();
        for (int i = 0; i < 5; i++) begin
            req(0);
            trig_chk($sformatf("t3_%0d", i), i, i % 4);
            if (i == 0) begin
                req(1);
                chk("t3_dead_trig", trig_o, 0);
                rej_chk("t3_prio", 1, 0, 0);
            end
            idle(16);
        end

        // command backpressure
        cmd_ready_i = 1'b0;
        run_reset();
        req(0);
        trig_chk("t4a", 0, 0);
        idle(19);
        req(0);
        chk("t4_busy_trig", trig_o, 0);
        chk("t4_cmdv", cmd_valid_o, 1);
        chk("t4_cmdev", cmd_evnum_o, 0);
        rej_chk("t4", 0, 0, 1);
        idle(5);
        chk("t4_cmdv_held", cmd_valid_o, 1);
        cmd_ready_i = 1'b1;
        req(0);
        trig_chk("t4b", 1, 1);
        chk("t4b_cmdv", cmd_valid_o, 1);
        chk("t4b_cmdev", cmd_evnum_o, 1);
        chk("t4b_cmdbuf", cmd_buf_o, 1);
        idle(1);
        chk("t4_cmd_done", cmd_valid_o, 0);
        idle(1);
        chk("t4_ready_idle", cmd_valid_o, 0);

        // runrst + runstop + req while a command is pending
        idle(20);
        cmd_ready_i = 1'b0;
        run_reset();
        req(0);
        chk("t5_pending", cmd_valid_o, 1);
        idle(2);
        req(1);
        chk("t5_dead", rej_dead_o, 1);
        idle(20);
        runrst_i = 1'b1; runstop_i = 1'b1; trig_req_i = 1'b1;
        @(negedge sys_clk_i);
        runrst_i = 1'b0; runstop_i = 1'b0; trig_req_i = 1'b0;
        chk("t5_running", running_o, 1);
        chk("t5_cmdv", cmd_valid_o, 0);
        chk("t5_trig", trig_o, 0);
        rej_chk("t5", 0, 0, 0);
        cmd_ready_i = 1'b1;
        req(0);
        trig_chk("t5b", 0, 0);

        // saturation, then requests in STOP are ignored
        force dut.u_rej_dead.cnt_q = 16'hFFFE;
        @(negedge sys_clk_i);
        release dut.u_rej_dead.cnt_q;
        chk("t6_preset", rej_dead_o, 16'hFFFE);
        req(1);
        chk("t6_sat1", rej_dead_o, 16'hFFFF);
        req(1);
        req(1);
        chk("t6_sat3", rej_dead_o, 16'hFFFF);
        runstop_i = 1'b1;
        @(negedge sys_clk_i);
        runstop_i = 1'b0;
        chk("t6_stopped", running_o, 0);
        idle(20);
        req(0);
        chk("t6_stop_trig", trig_o, 0);
        chk("t6_stop_cmdv", cmd_valid_o, 0);
        rej_chk("t6_stop", 16'hFFFF, 0, 0);
        req(1);
        chk("t6_stop_dead", rej_dead_o, 16'hFFFF);
        chk("t6_stop_trig2", trig_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/trig_issue_gate.md
Name: trig_issue_gate

Overview:
- Master trigger issue stage, directly upstream of the buffer tracker.
- Qualifies raw trigger requests against dead, run state, a minimum-spacing holdoff and the readout-command handshake.
- Each accepted trigger produces a 1-cycle trig_o pulse, which feeds the tracker's trig input.
- Each accepted trigger also gets an event number and a round-robin SURF buffer index, and raises a held command toward the readout/command path.
- Rejected requests are counted by reason for monitoring.

Parameters:
- HOLDOFF, 16: minimum cycles from one accepted trigger to the next acceptance; 0 disables the holdoff.
- NBUF, 4: number of SURF buffers; must be a power of 2.
- EVNUM_WIDTH, 32: width of the event number.
- REJ_WIDTH, 16: width of each saturating reject counter.

Ports:
- sys_clk_i  in  1  system clock; the only clock in the block.
- rst_i  in  1  synchronous, active-high reset.
- runrst_i  in  1  run reset pulse; starts a run.
- runstop_i  in  1  run stop pulse.
- trig_req_i  in  1  raw trigger request, 1 cycle per request.
- dead_i  in  1  deadtime from the buffer tracker.
- trig_o  out  1  accepted-trigger pulse.
- trig_buf_o  out  $clog2(NBUF)  buffer index of the trigger on trig_o.
- trig_evnum_o  out  EVNUM_WIDTH  event number of the trigger on trig_o.
- cmd_valid_o  out  1  readout command valid.
- cmd_ready_i  in  1  readout command ready.
- cmd_buf_o  out  $clog2(NBUF)  buffer index of the pending command.
- cmd_evnum_o  out  EVNUM_WIDTH  event number of the pending command.
- running_o  out  1  high while in RUN.
- rej_dead_o  out  REJ_WIDTH  count of requests rejected for dead.
- rej_holdoff_o  out  REJ_WIDTH  count of requests rejected for holdoff.
- rej_busy_o  out  REJ_WIDTH  count of requests rejected because a command was pending.

Behaviour:
- rst_i:
  - State goes to STOP.
  - All outputs and counters go to 0; evnum = 0, buf_idx = 0, holdoff_cnt = 0.
- State machine STOP/RUN:
  - runrst_i moves any state to RUN.
  - runstop_i moves RUN to STOP.
  - If runrst_i and runstop_i arrive together, runrst_i wins.
  - running_o is registered and equals (state == RUN).
- runrst_i additionally clears evnum, buf_idx, holdoff_cnt, all reject counters and cmd_valid_o. A pending command is dropped.
- A trig_req_i in the same cycle as runrst_i is ignored: not accepted, not counted.
- Accept condition, evaluated at cycle N: state == RUN && trig_req_i && !dead_i && holdoff_cnt == 0 && (!cmd_valid_o || cmd_ready_i).
- On accept at cycle N, at N+1:
  - trig_o = 1 for exactly 1 cycle.
  - trig_buf_o and trig_evnum_o carry the pre-increment buf_idx and evnum.
  - cmd_valid_o = 1, and cmd_buf_o/cmd_evnum_o are loaded with the same values.
  - evnum increments, wrapping at 2^EVNUM_WIDTH.
  - buf_idx increments modulo NBUF.
  - holdoff_cnt loads HOLDOFF-1. With HOLDOFF = 1 or 0 the load is 0, so back-to-back acceptance is allowed.
- holdoff_cnt decrements by 1 per cycle while non-zero, in both RUN and STOP.
- trig_buf_o and trig_evnum_o hold their last value between pulses.
- Command handshake:
  - cmd_valid_o stays high and cmd_* stay stable until a cycle with cmd_ready_i = 1.
  - If ready completes and a new accept happens in the same cycle, cmd_valid_o stays 1 and cmd_* take the new values.
  - cmd_ready_i with !cmd_valid_o is ignored.
- Reject: a request in RUN that is not accepted increments exactly one counter, chosen by priority dead > holdoff > busy.
  - Counters saturate at all-ones and never wrap.
- Requests in STOP are ignored: not accepted, not counted.
- runstop_i does not clear a pending command. It must still complete by handshake.

Decomposition:
- trig_pkg holds:
  - typedef trig_state_t {STOP, RUN}.
  - typedef rej_reason_t {REJ_NONE, REJ_DEAD, REJ_HOLDOFF, REJ_BUSY}.
  - NBUF_DEFAULT = 4 and HOLDOFF_DEFAULT = 16.
  - typedef buf_idx_t = logic [$clog2(NBUF_DEFAULT)-1:0].
- Sub-module trig_reject_counter:
  - Saturating REJ_WIDTH counter with synchronous clear and an increment enable.
  - Instantiated 3 times, one per reject reason.
- The accept/reason decode stays in the top level.

Test Plan:
- rst, runrst at cycle 0, trig_req at cycles 5 and 30, cmd_ready_i = 1 -> trig_o at cycles 6 and 31; evnum 0 then 1; buf 0 then 1; no reject counts.
- HOLDOFF = 16, req at cycle 10 (accepted) and cycle 20 -> rej_holdoff_o = 1; next req at cycle 26 is accepted (evnum 1).
- dead_i = 1 with a req during holdoff -> rej_dead_o = 1 and rej_holdoff_o = 0 (priority check); 5 accepts -> buf sequence 0,1,2,3,0.
- cmd_ready_i = 0 for 40 cycles with reqs at cycles 0 and 20 -> cmd_valid_o held with evnum 0, rej_busy_o = 1; ready and a new req in the same cycle -> cmd_* update without cmd_valid_o dropping.
- runrst_i together with runstop_i and trig_req_i while a command is pending -> state RUN, cmd_valid_o = 0, evnum = 0, counters 0, no trig_o.
- Force a reject counter to 0xFFFE, then 3 rejects -> stays at 0xFFFF; runstop_i then req -> no trig_o and no count.
